eb_pack: RTL and testbench



---
 rtl/eb_pack.sv | 102 ++++++++++
 tb/tb_eb_pack.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eb_pack.sv
`default_nettype none
// ============================================================================
// eb_pack : width-up gearbox packing RATIO narrow beats into one wide word.
// Rev 1.0
// ============================================================================
module eb_pack #(
   parameter int T_0_WIDTH  = 8,
   parameter int RATIO      = 4,
   parameter int I_0_WIDTH  = T_0_WIDTH * RATIO,
   parameter int KEEP_WIDTH = $clog2(RATIO) + 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [T_0_WIDTH-1:0]  t0_data,
   input  logic                  t0_valid,
   input  logic                  t0_last,
   output logic                  t0_ready,
   output logic [I_0_WIDTH-1:0]  i0_data,
   output logic [KEEP_WIDTH-1:0] i0_keep,
   output logic                  i0_last,
   output logic                  i0_valid,
   input  logic                  i0_ready
);

   localparam int CNT_W = $clog2(RATIO);

   logic [CNT_W-1:0]      cnt_q,   cnt_d;
   logic [I_0_WIDTH-1:0]  asm_q,   asm_d;
   logic [I_0_WIDTH-1:0]  data_q,  data_d;
   logic [KEEP_WIDTH-1:0] keep_q,  keep_d;
   logic                  last_q,  last_d;
   logic                  valid_q, valid_d;

   logic                  w_accept;
   logic                  w_emit;
   logic [I_0_WIDTH-1:0]  w_asm_beat;

   // Stall only while a finished word waits; emission needs the output slot.
   assign t0_ready = !valid_q || i0_ready;
   assign w_accept = t0_valid && t0_ready;
   assign w_emit   = w_accept && ((cnt_q == CNT_W'(RATIO - 1)) || t0_last);

   // Lanes above the counter are still zero because the register clears on emit.
   always_comb begin
      w_asm_beat = asm_q;
      for (int k = 0; k < RATIO; k++) begin
         if (cnt_q == CNT_W'(k)) begin
            w_asm_beat[k*T_0_WIDTH +: T_0_WIDTH] = t0_data;
         end
      end
   end

   always_comb begin
      cnt_d   = cnt_q;
      asm_d   = asm_q;
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      valid_d = valid_q;

      if (valid_q && i0_ready) begin
         valid_d = 1'b0;
      end

      if (w_emit) begin
         cnt_d   = '0;
         asm_d   = '0;
         data_d  = w_asm_beat;
         keep_d  = {1'b0, cnt_q} + KEEP_WIDTH'(1);
         last_d  = t0_last;
         valid_d = 1'b1;
      end else if (w_accept) begin
         cnt_d   = cnt_q + CNT_W'(1);
         asm_d   = w_asm_beat;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         asm_q   <= '0;
         data_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
         data_q  <= data_d;
         keep_q  <= keep_d;
         last_q  <= last_d;
         valid_q <= valid_d;
      end
   end

   assign i0_data  = data_q;
   assign i0_keep  = keep_q;
   assign i0_last  = last_q;
   assign i0_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_eb_pack.sv
`default_nettype none
// ============================================================================
// tb_eb_pack : directed and randomized checks of the eb_pack width-up packer.
// Rev 1.0
// ============================================================================
module tb_eb_pack;

   localparam int TW = 8;
   localparam int R  = 4;
   localparam int IW = TW * R;
   localparam int KW = $clog2(R) + 1;
   localparam int NB = 10000;

   typedef struct {
      logic [IW-1:0] d;
      logic [KW-1:0] k;
      logic          l;
   } word_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [TW-1:0] t0_data = '0;
   logic          t0_valid = 1'b0;
   logic          t0_last = 1'b0;
   logic          t0_ready;
   logic [IW-1:0] i0_data;
   logic [KW-1:0] i0_keep;
   logic          i0_last;
   logic          i0_valid;
   logic          i0_ready = 1'b0;

   int errors = 0;
   int checks = 0;

   eb_pack #(.T_0_WIDTH(TW), .RATIO(R)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .t0_data  (t0_data),
      .t0_valid (t0_valid),
      .t0_last  (t0_last),
      .t0_ready (t0_ready),
      .i0_data  (i0_data),
      .i0_keep  (i0_keep),
      .i0_last  (i0_last),
      .i0_valid (i0_valid),
      .i0_ready (i0_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (i0_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", i0_valid); end
      checks++; if (i0_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", i0_data); end
      checks++; if (i0_keep !== '0) begin errors++; $display("FAIL reset_keep got=%0d exp=0", i0_keep); end
      checks++; if (i0_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", i0_last); end
      checks++; if (t0_ready !== 1'b1) begin errors++; $display("FAIL reset_t0_ready got=%b exp=1", t0_ready); end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_stream();
      t0_valid = 1'b1; t0_data = 8'h01; t0_last = 1'b0; i0_ready = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         t0_data  = 8'(k + 1);
         t0_valid = (k < 8);
         checks++;
         if (i0_valid !== (k % 4 == 0)) begin
            errors++; $display("FAIL stream_valid edge=%0d got=%b exp=%b", k, i0_valid, (k % 4 == 0));
         end
         checks++;
         if (t0_ready !== 1'b1) begin errors++; $display("FAIL stream_t0_ready edge=%0d got=%b exp=1", k, t0_ready); end
         if (k == 4) begin
            checks++;
            if ({i0_data, i0_keep, i0_last} !== {32'h04030201, 3'd4, 1'b0}) begin
               errors++; $display("FAIL stream_word1 got=%h/%0d/%b exp=04030201/4/0", i0_data, i0_keep, i0_last);
            end
         end
         if (k == 8) begin
            checks++;
            if ({i0_data, i0_keep, i0_last} !== {32'h08070605, 3'd4, 1'b0}) begin
               errors++; $display("FAIL stream_word2 got=%h/%0d/%b exp=08070605/4/0", i0_data, i0_keep, i0_last);
            end
         end
      end
   endtask

   task automatic test_partial();
      i0_ready = 1'b1;
      t0_valid = 1'b1; t0_data = 8'hAA; t0_last = 1'b0;
      tick();
      t0_data = 8'hBB; t0_last = 1'b1;
      tick();
      t0_valid = 1'b0; t0_last = 1'b0;
      checks++;
      if ({i0_valid, i0_data, i0_keep, i0_last} !== {1'b1, 32'h0000BBAA, 3'd2, 1'b1}) begin
         errors++; $display("FAIL partial_word got=%b/%h/%0d/%b exp=1/0000bbaa/2/1", i0_valid, i0_data, i0_keep, i0_last);
      end
      tick();
      checks++; if (i0_valid !== 1'b0) begin errors++; $display("FAIL partial_drop got=%b exp=0", i0_valid); end
   endtask

   task automatic test_single();
      t0_valid = 1'b1; t0_data = 8'h5C; t0_last = 1'b1;
      tick();
      t0_valid = 1'b0; t0_last = 1'b0;
      checks++;
      if ({i0_valid, i0_data, i0_keep, i0_last} !== {1'b1, 32'h0000005C, 3'd1, 1'b1}) begin
         errors++; $display("FAIL single_word got=%b/%h/%0d/%b exp=1/0000005c/1/1", i0_valid, i0_data, i0_keep, i0_last);
      end
      tick();
   endtask

   task automatic test_backpressure();
      i0_ready = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         t0_valid = 1'b1; t0_data = 8'(k); t0_last = 1'b0;
         tick();
      end
      t0_data = 8'h05;
      checks++;
      if ({i0_valid, i0_data, i0_keep, i0_last} !== {1'b1, 32'h04030201, 3'd4, 1'b0}) begin
         errors++; $display("FAIL bp_word got=%b/%h/%0d/%b exp=1/04030201/4/0", i0_valid, i0_data, i0_keep, i0_last);
      end
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if ({i0_valid, i0_data, i0_keep, i0_last} !== {1'b1, 32'h04030201, 3'd4, 1'b0}) begin
            errors++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%0d/%b exp=1/04030201/4/0", c, i0_valid, i0_data, i0_keep, i0_last);
         end
         checks++; if (t0_ready !== 1'b0) begin errors++; $display("FAIL bp_t0_ready cyc=%0d got=%b exp=0", c, t0_ready); end
      end
      i0_ready = 1'b1;
      tick();
      checks++; if (i0_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b exp=0", i0_valid); end
      for (int k = 6; k <= 8; k++) begin
         t0_data = 8'(k);
         tick();
      end
      t0_valid = 1'b0;
      checks++;
      if ({i0_valid, i0_data, i0_keep, i0_last} !== {1'b1, 32'h08070605, 3'd4, 1'b0}) begin
         errors++; $display("FAIL bp_next got=%b/%h/%0d/%b exp=1/08070605/4/0", i0_valid, i0_data, i0_keep, i0_last);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      for (int s = 0; s < 2; s++) begin
         // s=0: two lanes filled; s=1: a finished word is pending
         i0_ready = (s == 0);
         for (int k = 0; k < ((s == 0) ? 2 : 4); k++) begin
            t0_valid = 1'b1; t0_data = 8'(8'h21 + k); t0_last = 1'b0;
            tick();
         end
         t0_valid = 1'b0;
         if (s == 1) begin
            checks++; if (i0_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pending got=%b exp=1", i0_valid); end
         end
         #2;
         reset_n = 1'b0;
         #1;
         checks++;
         if ({i0_valid, i0_data, i0_keep, i0_last} !== {1'b0, 32'h0, 3'd0, 1'b0}) begin
            errors++; $display("FAIL rstmid_async s=%0d got=%b/%h/%0d/%b exp=0/0/0/0", s, i0_valid, i0_data, i0_keep, i0_last);
         end
         @(negedge clk);
         reset_n = 1'b1;
         i0_ready = 1'b1;
         tick();
         checks++; if (i0_valid !== 1'b0) begin errors++; $display("FAIL rstmid_spurious s=%0d got=%b exp=0", s, i0_valid); end
         for (int k = 0; k < 4; k++) begin
            t0_valid = 1'b1; t0_data = 8'(8'h11 + k); t0_last = 1'b0;
            tick();
         end
         t0_valid = 1'b0;
         checks++;
         if ({i0_valid, i0_data, i0_keep, i0_last} !== {1'b1, 32'h14131211, 3'd4, 1'b0}) begin
            errors++; $display("FAIL rstmid_word s=%0d got=%b/%h/%0d/%b exp=1/14131211/4/0", s, i0_valid, i0_data, i0_keep, i0_last);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [TW-1:0] part[$];
      word_t         exp_q[$];
      word_t         w;
      word_t         prev;
      bit            prev_hold = 0;
      bit            have = 0;
      logic [TW-1:0] bd = '0;
      bit            bl = 0;
      int            sent = 0;
      int            cyc = 0;
      int            words = 0;
      prev = '{d: '0, k: '0, l: 1'b0};
      while ((sent < NB || have || exp_q.size() != 0) && cyc < 60000) begin
         if (!have && sent < NB && ($urandom % 4 != 0)) begin
            have = 1;
            bd   = 8'($urandom);
            bl   = (sent == NB - 1) || ($urandom % 6 == 0);
         end
         t0_valid = have; t0_data = bd; t0_last = bl;
         i0_ready = ($urandom % 3 != 0);
         @(negedge clk);
         checks++;
         if (t0_ready !== (!i0_valid || i0_ready)) begin
            errors++; $display("FAIL b2b_t0_ready cyc=%0d got=%b exp=%b", cyc, t0_ready, (!i0_valid || i0_ready));
         end
         if (prev_hold) begin
            checks++;
            if ({i0_valid, i0_data, i0_keep, i0_last} !== {1'b1, prev.d, prev.k, prev.l}) begin
               errors++; $display("FAIL b2b_hold cyc=%0d got=%b/%h/%0d/%b exp=1/%h/%0d/%b",
                                  cyc, i0_valid, i0_data, i0_keep, i0_last, prev.d, prev.k, prev.l);
            end
         end
         if (i0_valid && i0_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL b2b_extra cyc=%0d got=%h/%0d/%b exp=no word", cyc, i0_data, i0_keep, i0_last);
            end else begin
               w = exp_q.pop_front();
               words++;
               if ({i0_data, i0_keep, i0_last} !== {w.d, w.k, w.l}) begin
                  errors++; $display("FAIL b2b_word n=%0d got=%h/%0d/%b exp=%h/%0d/%b",
                                     words, i0_data, i0_keep, i0_last, w.d, w.k, w.l);
               end
            end
         end
         prev_hold = i0_valid && !i0_ready;
         prev = '{d: i0_data, k: i0_keep, l: i0_last};
         if (t0_valid && t0_ready) begin
            part.push_back(bd);
            if (part.size() == R || bl) begin
               w.d = '0;
               foreach (part[i]) w.d[i*TW +: TW] = part[i];
               w.k = KW'(part.size());
               w.l = bl;
               exp_q.push_back(w);
               part.delete();
            end
            have = 0;
            sent++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      t0_valid = 1'b0; t0_last = 1'b0; i0_ready = 1'b1;
      checks++;
      if (cyc >= 60000 || exp_q.size() != 0 || part.size() != 0 || sent != NB) begin
         errors++; $display("FAIL b2b_drain cyc=%0d sent=%0d pending=%0d partial=%0d exp=all %0d beats drained",
                            cyc, sent, exp_q.size(), part.size(), NB);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_partial();
      test_single();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
